// File: rtl/sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Shares one sprite ROM between four pixel-fetch requesters
// (0 Mario, 1 enemy, 2 block/tile, 3 coin/score). One read is granted per
// clock. Each accepted read carries a tag down a pipeline that matches the ROM
// latency. When the word comes back, it is handed to its owner with a one-hot
// strobe.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   stall      1 = issue no new grants (in-flight reads still complete)
//   req        per-requester request, held until granted
//   sprite_id  4 x 6-bit frame id, requester k at [6k+5:6k]
//   offset     4 x 10-bit pixel index {y,x}, requester k at [10k+9:10k]
//   gnt        one-hot combinational grant for the current cycle
//   rom_en     registered ROM read enable
//   rom_addr   registered {sprite_id, offset} of the accepted request
//   rom_data   RGB444 word from the ROM
//   rd_valid   one-hot, one-cycle return strobe (registered)
//   rd_data    registered returned pixel word
//   busy       1 while any read is in flight
// -----------------------------------------------------------------------------
module sprite_rom_arbiter #(
  parameter int unsigned ROM_LAT    = 32'd2,
  parameter int unsigned MARIO_PRIO = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [3:0]  req,
  input  logic [23:0] sprite_id,
  input  logic [39:0] offset,
  output logic [3:0]  gnt,
  output logic        rom_en,
  output logic [15:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [3:0]  rd_valid,
  output logic [11:0] rd_data,
  output logic        busy
);

  localparam bit PRIO_EN = (MARIO_PRIO == 32'd1);

  // Round-robin search: first set bit after ptr, wrapping; returns {found, idx}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int i = 1; i < 5; i++) begin
      cand = ptr + 2'(i);
      if (!res[2] && r[cand]) begin
        res = {1'b1, cand};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [15:0] pick_addr(input logic [1:0] idx,
                                            input logic [23:0] sid,
                                            input logic [39:0] off);
    logic [15:0] a;
    case (idx)
      2'd0:    a = {sid[5:0],   off[9:0]};
      2'd1:    a = {sid[11:6],  off[19:10]};
      2'd2:    a = {sid[17:12], off[29:20]};
      2'd3:    a = {sid[23:18], off[39:30]};
      default: a = 16'h0000;
    endcase
    return a;
  endfunction

  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic                  last_was0_q, last_was0_d;
  logic                  rom_en_q, rom_en_d;
  logic [15:0]           rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0]      tag_vld_q, tag_vld_d;
  logic [ROM_LAT:0][1:0] tag_idx_q, tag_idx_d;
  logic [3:0]            rd_valid_q, rd_valid_d;
  logic [11:0]           rd_data_q, rd_data_d;

  logic [3:0] gnt_s;
  logic [2:0] pick_s;
  logic       prio_s;
  logic       accept_s;
  logic [1:0] acc_idx_s;

  // Grant selection: Mario override first, then round-robin from rr_ptr+1.
  always_comb begin
    gnt_s  = 4'b0000;
    pick_s = 3'b000;
    prio_s = 1'b0;
    if (!rst || stall || (req == 4'b0000)) begin
      gnt_s = 4'b0000;
    end else if (PRIO_EN && req[0] && !last_was0_q) begin
      prio_s = 1'b1;
      gnt_s  = 4'b0001;
    end else begin
      // Right after a Mario grant, Mario only wins if nobody else is waiting.
      if (PRIO_EN && last_was0_q && ((req & 4'b1110) != 4'b0000)) begin
        pick_s = rr_pick(req & 4'b1110, rr_ptr_q);
      end else begin
        pick_s = rr_pick(req, rr_ptr_q);
      end
      gnt_s = pick_s[2] ? onehot4(pick_s[1:0]) : 4'b0000;
    end
  end

  assign accept_s  = |gnt_s;
  assign acc_idx_s = prio_s ? 2'd0 : pick_s[1:0];

  // Next-state: rotation pointer, issue registers, tag pipeline and return.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    last_was0_d = 1'b0;
    rom_en_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    tag_vld_d   = {tag_vld_q[ROM_LAT-1:0], accept_s};
    tag_idx_d   = {tag_idx_q[ROM_LAT-1:0], (accept_s ? acc_idx_s : 2'b00)};
    rd_valid_d  = 4'b0000;
    rd_data_d   = rd_data_q;
    if (accept_s) begin
      // A Mario override grant leaves the rotation where it was, so the
      // other three still take turns in between Mario's fetches.
      rr_ptr_d    = prio_s ? rr_ptr_q : acc_idx_s;
      last_was0_d = (acc_idx_s == 2'd0);
      rom_en_d    = 1'b1;
      rom_addr_d  = pick_addr(acc_idx_s, sprite_id, offset);
    end else begin
      rr_ptr_d    = rr_ptr_q;
      last_was0_d = 1'b0;
    end
    if (tag_vld_q[ROM_LAT]) begin
      rd_valid_d = onehot4(tag_idx_q[ROM_LAT]);
      rd_data_d  = rom_data;
    end else begin
      rd_valid_d = 4'b0000;
      rd_data_d  = rd_data_q;
    end
  end

  // State registers; reset discards every in-flight tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= 2'd3;
      last_was0_q <= 1'b0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= 16'h0000;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      rd_valid_q  <= 4'b0000;
      rd_data_q   <= 12'h000;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      last_was0_q <= last_was0_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign gnt      = gnt_s;
  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign busy     = rom_en_q | (|tag_vld_q);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for sprite_rom_arbiter. Three instances share clock, reset, stall and
// request fields:
//   inst 0: ROM_LAT=2, MARIO_PRIO=1
//   inst 1: ROM_LAT=1, MARIO_PRIO=0
//   inst 2: ROM_LAT=4, MARIO_PRIO=0
// Each instance has its own request vector and its own ROM model.
// Stimulus pushes every expected return into a per-instance queue. A negedge
// monitor pops one entry per rd_valid and compares it.
// -----------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

  typedef struct {
    logic [3:0]  vld;
    logic [11:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [23:0] sprite_id;
  logic [39:0] offset;
  logic [3:0]  req_v      [3];
  logic [3:0]  gnt_v      [3];
  logic        rom_en_v   [3];
  logic [15:0] rom_addr_v [3];
  logic [11:0] rom_data_v [3];
  logic [3:0]  rd_valid_v [3];
  logic [11:0] rd_data_v  [3];
  logic        busy_v     [3];

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  function automatic logic [11:0] rom_fn(input logic [15:0] a);
    return a[11:0] ^ {a[15:10], a[15:10]} ^ 12'h5a3;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 32'd2 : ((g == 1) ? 32'd1 : 32'd4);
    localparam int unsigned PRI = (g == 0) ? 32'd1 : 32'd0;
    logic [15:0] pipe [LAT];

    sprite_rom_arbiter #(.ROM_LAT(LAT), .MARIO_PRIO(PRI)) u_dut (
      .clk       (clk),
      .rst       (rst_n),
      .stall     (stall),
      .req       (req_v[g]),
      .sprite_id (sprite_id),
      .offset    (offset),
      .gnt       (gnt_v[g]),
      .rom_en    (rom_en_v[g]),
      .rom_addr  (rom_addr_v[g]),
      .rom_data  (rom_data_v[g]),
      .rd_valid  (rd_valid_v[g]),
      .rd_data   (rd_data_v[g]),
      .busy      (busy_v[g])
    );

    // ROM model: address registered at edge E gives its word after edge E+LAT.
    always @(posedge clk) begin
      pipe[0] <= rom_addr_v[g];
      for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign rom_data_v[g] = rom_fn(pipe[LAT-1]);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare gnt with the hand-expected value and queue the resulting return.
  task automatic expect_gnt(input int inst, input logic [3:0] exp_g, input string nm);
    int          idx;
    exp_t        e;
    logic [15:0] a;
    check(gnt_v[inst] == exp_g, nm, 32'(gnt_v[inst]), 32'(exp_g));
    if (exp_g != 4'b0000) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (exp_g[k]) idx = k;
      a = {sprite_id[6*idx +: 6], offset[10*idx +: 10]};
      e.vld  = exp_g;
      e.data = rom_fn(a);
      e.due  = cyc + 1 + lat_of(inst) + 1;
      case (inst)
        0:       qa.push_back(e);
        1:       qb.push_back(e);
        default: qc.push_back(e);
      endcase
    end
  endtask

  task automatic pop_check(input int inst);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (inst)
      0:       if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      1:       if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
    endcase
    n_checks++;
    if (!have) begin
      $display("FAIL unexpected_ret inst%0d: got vld=%b data=%h cyc=%0d expected no return",
               inst, rd_valid_v[inst], rd_data_v[inst], cyc);
    end else if (rd_valid_v[inst] == e.vld && rd_data_v[inst] == e.data && cyc == e.due) begin
      n_pass++;
    end else begin
      $display("FAIL ret inst%0d: got vld=%b data=%h cyc=%0d expected vld=%b data=%h cyc=%0d",
               inst, rd_valid_v[inst], rd_data_v[inst], cyc, e.vld, e.data, e.due);
    end
  endtask

  // Return monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_valid_v[i] != 4'b0000) pop_check(i);
    end
  end

  logic [3:0] mario_seq [8];
  logic [3:0] rr_seq    [8];
  logic [9:0] off0;
  int         last_f;

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_pass   = 0;
    mario_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b0001, 4'b1000, 4'b0001, 4'b0010};
    rr_seq    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    sprite_id = {6'd46, 6'd42, 6'd36, 6'd32};
    offset    = {10'd400, 10'd300, 10'd200, 10'd37};
    stall     = 1'b0;
    rst_n     = 1'b0;
    req_v[0]  = 4'b1111;
    req_v[1]  = 4'b0000;
    req_v[2]  = 4'b0000;

    // Reset state, with requests present.
    step();
    step();
    check(gnt_v[0] == 4'b0000, "rst_gnt", 32'(gnt_v[0]), 32'h0);
    check(rom_en_v[0] == 1'b0 && rom_addr_v[0] == 16'h0000, "rst_rom",
          {15'h0, rom_en_v[0], rom_addr_v[0]}, 32'h0);
    check(rd_valid_v[0] == 4'b0000 && rd_data_v[0] == 12'h000 && busy_v[0] == 1'b0,
          "rst_ret", {15'h0, busy_v[0], rd_valid_v[0], rd_data_v[0]}, 32'h0);
    req_v[0] = 4'b0000;
    #1 rst_n = 1'b1;
    step();

    // Single read from Mario.
    req_v[0] = 4'b0001;
    #2 expect_gnt(0, 4'b0001, "single_gnt");
    step();
    req_v[0] = 4'b0000;
    check(rom_en_v[0] == 1'b1 && rom_addr_v[0] == 16'h8025, "single_issue",
          {15'h0, rom_en_v[0], rom_addr_v[0]}, 32'h18025);
    check(busy_v[0] == 1'b1, "single_busy", 32'(busy_v[0]), 32'h1);
    repeat (5) step();

    // Mario priority with all four requesting.
    for (int i = 0; i < 8; i++) begin
      req_v[0] = 4'b1111;
      #2 expect_gnt(0, mario_seq[i], $sformatf("prio_gnt%0d", i));
      step();
    end
    req_v[0] = 4'b0000;
    repeat (6) step();

    // Stall: bring rr_ptr to 3, then stall with 1 and 2 pending.
    req_v[0] = 4'b1000;
    #2 expect_gnt(0, 4'b1000, "stall_pre");
    step();
    stall    = 1'b1;
    req_v[0] = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      #2 check(gnt_v[0] == 4'b0000, "stall_gnt", 32'(gnt_v[0]), 32'h0);
      step();
      check(rom_en_v[0] == 1'b0, "stall_rom_en", 32'(rom_en_v[0]), 32'h0);
    end
    stall = 1'b0;
    #2 expect_gnt(0, 4'b0010, "stall_release");
    step();
    req_v[0] = 4'b0100;
    #2 expect_gnt(0, 4'b0100, "stall_next");
    step();
    req_v[0] = 4'b0000;
    repeat (6) step();

    // Reset while two reads are in flight.
    req_v[0] = 4'b0001;
    #2 expect_gnt(0, 4'b0001, "mid_gnt0");
    step();
    req_v[0] = 4'b0010;
    #2 expect_gnt(0, 4'b0010, "mid_gnt1");
    step();
    req_v[0] = 4'b0000;
    step();
    rst_n = 1'b0;
    qa.delete();
    #1;
    check(rom_en_v[0] == 1'b0 && rom_addr_v[0] == 16'h0000, "mid_rst_rom",
          {15'h0, rom_en_v[0], rom_addr_v[0]}, 32'h0);
    check(rd_valid_v[0] == 4'b0000 && rd_data_v[0] == 12'h000 && busy_v[0] == 1'b0,
          "mid_rst_ret", {15'h0, busy_v[0], rd_valid_v[0], rd_data_v[0]}, 32'h0);
    step();
    rst_n = 1'b1;
    repeat (6) step();
    req_v[0] = 4'b1111;
    #2 expect_gnt(0, 4'b0001, "post_rst_gnt0");
    step();
    #2 expect_gnt(0, 4'b0010, "post_rst_gnt1");
    step();
    req_v[0] = 4'b0000;
    repeat (5) step();

    // Pure round-robin on the ROM_LAT=1 instance.
    for (int i = 0; i < 8; i++) begin
      req_v[1] = 4'b1111;
      #2 expect_gnt(1, rr_seq[i], $sformatf("rr_gnt%0d", i));
      step();
    end
    req_v[1] = 4'b0000;
    repeat (4) step();

    // Latency sweep: 16 back-to-back reads on ROM_LAT=1 and ROM_LAT=4.
    last_f = 0;
    for (int i = 0; i < 16; i++) begin
      off0     = 10'd100 + 10'(i * 37);
      offset   = {10'd400, 10'd300, 10'd200, off0};
      req_v[1] = 4'b0001;
      req_v[2] = 4'b0001;
      #2;
      expect_gnt(1, 4'b0001, $sformatf("lat1_gnt%0d", i));
      expect_gnt(2, 4'b0001, $sformatf("lat4_gnt%0d", i));
      last_f = cyc + 1;
      step();
    end
    req_v[1] = 4'b0000;
    req_v[2] = 4'b0000;
    step();
    check(busy_v[1] == 1'b1, "lat1_busy_hi", 32'(busy_v[1]), 32'h1);
    step();
    check(busy_v[1] == 1'b0, "lat1_busy_lo", 32'(busy_v[1]), 32'h0);
    check(busy_v[2] == 1'b1, "lat4_busy_mid", 32'(busy_v[2]), 32'h1);
    step();
    step();
    check(busy_v[2] == 1'b1 && cyc == last_f + 4, "lat4_busy_hi",
          32'(busy_v[2]), 32'h1);
    step();
    check(busy_v[2] == 1'b0, "lat4_busy_lo", 32'(busy_v[2]), 32'h0);

    // Drain any outstanding expectations (bounded wait).
    for (int k = 0; k < 30 && (qa.size() + qb.size() + qc.size()) > 0; k++) step();
    check((qa.size() + qb.size() + qc.size()) == 0, "drain",
          32'(qa.size() + qb.size() + qc.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
